// File: rtl/stateless_pkg.sv
// stateless_pkg: opcode encoding and helpers shared by the stateless ALU pipeline
package stateless_pkg;
   localparam int OP_W = 4;
   typedef enum logic [OP_W-1:0] {
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR, OP_ADDC, OP_SUBC, OP_EQ,
      OP_NE, OP_GE, OP_LT, OP_SHL, OP_SHR, OP_SEL, OP_MIN, OP_MAX
   } opcode_t;
   function automatic logic shift_ok(input logic [127:0] amt, input int unsigned width);
      return amt < 128'(width);
   endfunction
endpackage

// File: rtl/stateless_lane.sv
// stateless_lane: combinational single-lane ALU producing a result and carry/borrow flag
module stateless_lane
   import stateless_pkg::*;
#(
   parameter int W = 32,
   parameter bit SIGNED = 1'b0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] p3,
   input  logic [W-1:0] c,
   input  opcode_t      opcode,
   output logic [W-1:0] result,
   output logic         carry
);
   logic [W-1:0] rhs;
   logic [W:0] sum, diff;
   logic lt, sh_ok;
   assign rhs   = (opcode == OP_ADDC || opcode == OP_SUBC) ? c : b;
   assign sum   = {1'b0, a} + {1'b0, rhs};
   assign diff  = {1'b0, a} - {1'b0, rhs};
   assign lt    = SIGNED ? ($signed(a) < $signed(b)) : (a < b);
   assign sh_ok = shift_ok(128'(c), W);
   // opcode decode; the zero-extended difference's top bit is exactly the unsigned borrow
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (opcode)
         OP_ADD, OP_ADDC: {carry, result} = sum;
         OP_SUB, OP_SUBC: {carry, result} = diff;
         OP_AND: result = a & b;
         OP_XOR: result = a ^ b;
         OP_OR:  result = a | b;
         OP_EQ:  result = W'(a == b);
         OP_NE:  result = W'(a != b);
         OP_GE:  result = W'(!lt);
         OP_LT:  result = W'(lt);
         OP_SHL: result = sh_ok ? a << c : '0;
         OP_SHR: result = sh_ok ? a >> c : '0;
         OP_SEL: result = (a != '0) ? b : p3;
         OP_MIN: result = lt ? a : b;
         OP_MAX: result = lt ? b : a;
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/stateless_pipe.sv
// stateless_pipe: NUM_LANES-wide two-stage ALU pipeline with valid/ready flow control
module stateless_pipe
   import stateless_pkg::*;
#(
   parameter int COUNT_WIDTH = 32,
   parameter int NUM_LANES = 2,
   parameter bit SIGNED = 1'b0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [3:0]                       opcode,
   input  logic [COUNT_WIDTH-1:0]           cons_1,
   input  logic [NUM_LANES*COUNT_WIDTH-1:0] pkt_1,
   input  logic [NUM_LANES*COUNT_WIDTH-1:0] pkt_2,
   input  logic [NUM_LANES*COUNT_WIDTH-1:0] pkt_3,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NUM_LANES*COUNT_WIDTH-1:0] o_write,
   output logic [NUM_LANES-1:0]             o_carry,
   output logic [NUM_LANES*COUNT_WIDTH-1:0] o_read
);
   localparam int W  = COUNT_WIDTH;
   localparam int LW = NUM_LANES * COUNT_WIDTH;
   logic s1_valid, s2_load;
   opcode_t s1_op;
   logic [W-1:0] s1_c;
   logic [LW-1:0] s1_a, s1_b, s1_p3, res;
   logic [NUM_LANES-1:0] car;
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s2_load;
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      stateless_lane #(.W(W), .SIGNED(SIGNED)) u_lane (
         .a(s1_a[i*W +: W]),
         .b(s1_b[i*W +: W]),
         .p3(s1_p3[i*W +: W]),
         .c(s1_c),
         .opcode(s1_op),
         .result(res[i*W +: W]),
         .carry(car[i])
      );
   end
   // S1: capture operands on input handshake; valid falls only when S1 drains with no refill
   always_ff @(posedge clk) begin
      if (!rst_n) s1_valid <= 1'b0;
      else if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
         s1_a  <= pkt_1;
         s1_b  <= pkt_2;
         s1_p3 <= pkt_3;
         s1_c  <= cons_1;
         s1_op <= opcode_t'(opcode);
      end
   end
   // S2: register lane results, hold them under stall, and track the last consumed result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         o_write   <= '0;
         o_carry   <= '0;
         o_read    <= '0;
      end else begin
         if (!out_valid || out_ready) out_valid <= s1_valid;
         if (s2_load) begin
            o_write <= res;
            o_carry <= car;
         end
         if (out_valid && out_ready) o_read <= o_write;
      end
   end
endmodule

// File: tb/tb_stateless_pipe.sv
// tb_stateless_pipe: randomized and directed checks of stateless_pipe against a reference model
module tb_stateless_pipe;
   typedef struct {
      logic [1:0][63:0] w;
      logic [1:0][1:0]  c;
      int               t;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [3:0] opcode = '0;
   logic [31:0] cons_1 = '0;
   logic [63:0] pkt_1 = '0, pkt_2 = '0, pkt_3 = '0;
   logic [1:0] ir, ov;
   logic [1:0][63:0] ow, ordv;
   logic [1:0][1:0] oc;

   int n_tests = 0, n_fail = 0, cyc = 0;
   exp_t exp_q[$];
   logic [1:0][63:0] last_rd = '0, got_w = '0;
   logic [1:0][1:0] got_c = '0;
   logic [63:0] held_w = '0;
   logic [1:0] held_c = '0;
   bit stall_prev = 0, acc = 0, chk_lat = 0, saw_block = 0;

   always #5 clk = ~clk;

   for (genvar s = 0; s < 2; s++) begin : g_dut
      stateless_pipe #(.COUNT_WIDTH(32), .NUM_LANES(2), .SIGNED(s == 1)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[s]),
         .opcode(opcode), .cons_1(cons_1), .pkt_1(pkt_1), .pkt_2(pkt_2), .pkt_3(pkt_3),
         .out_valid(ov[s]), .out_ready(out_ready), .o_write(ow[s]), .o_carry(oc[s]),
         .o_read(ordv[s])
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {carry, result} from the opcode definitions using plain 64-bit arithmetic
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b, p3, c, input bit sgn);
      longint unsigned ua = 64'(a), ub = 64'(b), uc = 64'(c);
      longint sa = sgn ? longint'($signed(a)) : longint'(ua);
      longint sb = sgn ? longint'($signed(b)) : longint'(ub);
      case (op)
         4'd0:  return 33'(ua + ub);
         4'd1:  return {ub > ua, a - b};
         4'd2:  return {1'b0, a & b};
         4'd3:  return {1'b0, a ^ b};
         4'd4:  return {1'b0, a | b};
         4'd5:  return 33'(ua + uc);
         4'd6:  return {uc > ua, a - c};
         4'd7:  return 33'(a == b);
         4'd8:  return 33'(a != b);
         4'd9:  return 33'(sa >= sb);
         4'd10: return 33'(sa < sb);
         4'd11: return (uc >= 32) ? 33'd0 : {1'b0, 32'(ua << uc)};
         4'd12: return (uc >= 32) ? 33'd0 : 33'(ua >> uc);
         4'd13: return {1'b0, (a != 0) ? b : p3};
         4'd14: return {1'b0, (sa < sb) ? a : b};
         default: return {1'b0, (sa > sb) ? a : b};
      endcase
   endfunction

   function automatic exp_t model();
      exp_t e;
      logic [32:0] r;
      for (int s = 0; s < 2; s++)
         for (int l = 0; l < 2; l++) begin
            r = ref_alu(opcode, pkt_1[l*32 +: 32], pkt_2[l*32 +: 32], pkt_3[l*32 +: 32], cons_1, s == 1);
            e.w[s][l*32 +: 32] = r[31:0];
            e.c[s][l] = r[32];
         end
      e.t = cyc;
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h1;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic rnd_inputs();
      opcode = 4'($urandom_range(0, 15));
      pkt_1 = {pick(), pick()};
      pkt_2 = {pick(), pick()};
      pkt_3 = {pick(), pick()};
      cons_1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
   endtask

   // one clock: observe handshakes at negedge, update scoreboard, check o_read after the edge
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      acc = 0;
      if (stall_prev) begin
         check("stall_write", ow[0], held_w);
         check("stall_carry", 64'(oc[0]), 64'(held_c));
         check("stall_valid", 64'(ov[0]), 1);
      end
      stall_prev = rst_n && ov[0] && !out_ready;
      held_w = ow[0];
      held_c = oc[0];
      if (!rst_n) begin
         exp_q.delete();
         last_rd = '0;
      end else begin
         if (ov[0] && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else begin
               e = exp_q.pop_front();
               for (int s = 0; s < 2; s++) begin
                  check(s ? "write_s" : "write_u", ow[s], e.w[s]);
                  check(s ? "carry_s" : "carry_u", 64'(oc[s]), 64'(e.c[s]));
               end
               check("valid_s", 64'(ov[1]), 1);
               if (chk_lat) check("latency", 64'(cyc - e.t), 2);
               last_rd = e.w;
               got_w = ow;
               got_c = oc;
            end
         end
         if (!ir[0]) begin
            saw_block = 1;
            check("block_depth", 64'(exp_q.size()), 2);
         end
         if (in_valid && ir[0]) begin
            exp_q.push_back(model());
            acc = 1;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      check("read_u", ordv[0], last_rd[0]);
      check("read_s", ordv[1], last_rd[1]);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && (exp_q.size() != 0 || ov[0]); k++) cycle();
      check("drain", 64'(exp_q.size()), 0);
   endtask

   task automatic send(input logic [3:0] op, input logic [63:0] a, b, p3, input logic [31:0] c);
      bit done = 0;
      opcode = op; pkt_1 = a; pkt_2 = b; pkt_3 = p3; cons_1 = c; in_valid = 1;
      for (int k = 0; k < 20 && !done; k++) begin
         cycle();
         done = acc;
      end
      in_valid = 0;
      check("send_accept", 64'(done), 1);
      drain();
   endtask

   initial begin
      int sent;
      repeat (2) cycle();
      rst_n = 1;
      check("rst_valid", 64'(ov[0]), 0);
      check("rst_write", ow[0], 0);
      check("rst_carry", 64'(oc[0]), 0);
      check("rst_read", ordv[0], 0);
      check("rst_ready", 64'(ir[0]), 1);

      send(4'd0, {32'd5, 32'hFFFF_FFFF}, {32'd3, 32'd1}, '0, '0);
      check("add_w", got_w[0], {32'd8, 32'd0});
      check("add_c", 64'(got_c[0]), 2'b01);
      send(4'd1, {32'd10, 32'd3}, {32'd4, 32'd5}, '0, '0);
      check("sub_w", got_w[0], {32'd6, 32'hFFFF_FFFE});
      check("sub_c", 64'(got_c[0]), 2'b01);
      send(4'd11, {32'd1, 32'd1}, '0, '0, 32'd31);
      check("shl31", got_w[0], {2{32'h8000_0000}});
      send(4'd11, {32'd1, 32'd1}, '0, '0, 32'd32);
      check("shl32", got_w[0], 0);
      send(4'd12, {2{32'h8000_0000}}, '0, '0, 32'd31);
      check("shr31", got_w[0], {32'd1, 32'd1});
      send(4'd10, {32'd2, 32'hFFFF_FFFF}, {32'd3, 32'd1}, '0, '0);
      check("lt_signed", got_w[1], {32'd1, 32'd1});
      check("lt_unsigned", got_w[0], {32'd1, 32'd0});
      send(4'd14, {32'd2, 32'hFFFF_FFFF}, {32'd3, 32'd1}, '0, '0);
      check("min_signed", 64'(got_w[1][31:0]), 32'hFFFF_FFFF);
      send(4'd15, {32'd2, 32'hFFFF_FFFF}, {32'd3, 32'd1}, '0, '0);
      check("max_unsigned", 64'(got_w[0][31:0]), 32'hFFFF_FFFF);
      send(4'd13, {32'd0, 32'd7}, {32'hB1, 32'hB0}, {32'hC1, 32'hC0}, '0);
      check("select", got_w[0], {32'hC1, 32'hB0});

      // full throughput: a new beat every cycle, each result two edges later
      chk_lat = 1;
      out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         rnd_inputs();
         in_valid = 1;
         cycle();
         check("tput_accept", 64'(acc), 1);
      end
      in_valid = 0;
      drain();
      chk_lat = 0;

      // backpressure: five add beats, consumer stalled for cycles 3..6
      saw_block = 0;
      sent = 0;
      rnd_inputs();
      opcode = 4'd0;
      for (int k = 0; k < 30 && (sent < 5 || exp_q.size() != 0); k++) begin
         out_ready = !(k >= 3 && k <= 6);
         in_valid = sent < 5;
         cycle();
         if (acc) begin
            sent++;
            rnd_inputs();
            opcode = 4'd0;
         end
      end
      in_valid = 0;
      out_ready = 1;
      check("bp_sent", 64'(sent), 5);
      check("bp_blocked", 64'(saw_block), 1);
      drain();

      // reset with two beats in flight
      out_ready = 0;
      for (int k = 0; k < 2; k++) begin
         rnd_inputs();
         in_valid = 1;
         cycle();
      end
      in_valid = 0;
      rst_n = 0;
      cycle();
      rst_n = 1;
      check("mid_rst_valid", 64'(ov[0]), 0);
      check("mid_rst_write", ow[0], 0);
      check("mid_rst_read", ordv[0], 0);
      check("mid_rst_ready", 64'(ir[0]), 1);
      out_ready = 1;
      repeat (6) cycle();

      // randomized traffic on both signedness variants
      for (int k = 0; k < 600; k++) begin
         rnd_inputs();
         in_valid = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end
      in_valid = 0;
      out_ready = 1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
